// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle, signed/unsigned per operation.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: unsigned operations finish once the remaining multiplier bits are zero.
module seq_mul_unit #(
  parameter int A_W  = 16,
  parameter int B_W  = 8,
  parameter int STEP = 1,
  parameter int P_W  = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  input  logic           in_sgn,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [P_W-1:0] out_p,
  output logic           busy
);

  localparam int N  = B_W / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (B_W % STEP != 0) begin : g_step_chk
    $error("seq_mul_unit: STEP must divide B_W");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [P_W-1:0]  acc;
  logic [A_W-1:0]  a_r;
  logic [B_W-1:0]  b_r;
  logic            sgn_r;

  logic            last;
  logic [B_W-1:0]  b_sh;
  logic [STEP-1:0] chunk;
  logic [P_W-1:0]  a_ext;
  logic [P_W-1:0]  chunk_ext;
  logic [P_W-1:0]  prod;
  logic [P_W-1:0]  acc_next;
  logic            finish;

  // Partial product of the current chunk. Only the chunk holding b's MSB is
  // sign-extended in signed mode, which gives that bit its -2^(B_W-1) weight;
  // all arithmetic wraps at P_W bits, so two's-complement products come out exact.
  always_comb begin
    last      = (cnt == CW'(N - 1));
    b_sh      = b_r >> (int'(cnt) * STEP);
    chunk     = b_sh[STEP-1:0];
    a_ext     = {{B_W{sgn_r & a_r[A_W-1]}}, a_r};
    chunk_ext = {{(P_W-STEP){sgn_r & last & chunk[STEP-1]}}, chunk};
    prod      = a_ext * chunk_ext;
    acc_next  = acc + (prod << (int'(cnt) * STEP));
`ifdef SEQ_MUL_EARLY_TERM_EN
    finish    = last | (~sgn_r & ((b_r >> ((int'(cnt) + 1) * STEP)) == '0));
`else
    finish    = last;
`endif
  end

  // Operands are data only; they are loaded at the input handshake and need no reset.
  always_ff @(posedge clk) begin
    if (in_vld && in_rdy) begin
      a_r   <= in_a;
      b_r   <= in_b;
      sgn_r <= in_sgn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      out_p   <= '0;
      out_vld <= 1'b0;
      in_rdy  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            state  <= MUL;
            cnt    <= '0;
            acc    <= '0;
            in_rdy <= 1'b0;
            busy   <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (finish) begin
            state   <= DONE;
            out_p   <= acc_next;
            out_vld <= 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state   <= IDLE;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Parametrised iterative shift-add multiplier; successor to the single-width fixed-unsigned shift multiplier.
- Generalises operand widths and the number of multiplier bits retired per cycle (STEP).
- Adds per-operation signed/unsigned mode and valid/ready handshakes on both input and output.
- Operands are captured at handshake, so the upstream producer need not hold inputs. Sits between a datapath sequencer and a result FIFO.

Parameters:
- A_W, 16, multiplicand width in bits.
- B_W, 8, multiplier width in bits.
- STEP, 1, multiplier bits processed per MUL cycle. Must divide B_W; elaboration error otherwise.
- P_W, A_W+B_W, product width (derived; do not override).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_vld  in  1  operands valid.
- in_rdy  out  1  unit can accept operands.
- in_a  in  A_W  multiplicand.
- in_b  in  B_W  multiplier.
- in_sgn  in  1  1 = two's-complement operands; 0 = unsigned.
- out_vld  out  1  product valid.
- out_rdy  in  1  consumer accepts product.
- out_p  out  P_W  product.
- busy  out  1  high in MUL or DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; accumulator, out_p = 0; out_vld=0; in_rdy=1; busy=0; chunk counter=0.
- Reset asserted in any state aborts the operation at that edge. No result is emitted.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_rdy=1.
  - On in_vld&in_rdy at edge T: latch a, b, sgn; clear accumulator and counter; go to MUL.
- MUL:
  - in_rdy=0; in_vld and operand inputs are ignored.
  - Each edge adds the partial product of the current STEP-bit chunk of latched b, shifted by counter*STEP, into the P_W accumulator; counter increments.
  - After the last chunk (counter == B_W/STEP-1), go to DONE. That is edge T+B_W/STEP.
- DONE:
  - out_vld=1; out_p holds the final product, stable while out_rdy=0.
  - On out_vld&out_rdy: go to IDLE, out_vld=0 next cycle. out_p retains its value until the next result.
  - in_rdy=0 in DONE; a new operand pair is accepted no earlier than the cycle after the output handshake.
- Latency: out_vld rises at edge T+B_W/STEP (8 cycles at defaults).
  - Throughput: one result per B_W/STEP+2 cycles with out_rdy tied high.
- Arithmetic:
  - Unsigned mode: a is zero-extended to P_W.
  - Signed mode: a is sign-extended to P_W, and the b[B_W-1] term carries weight -2^(B_W-1). That term is subtracted instead of added, within the chunk that contains it.
  - All sums are modulo 2^P_W; the result is always the exact product, with no overflow possible.
- Boundaries:
  - b=0 or a=0 still runs the full count (unless the optional feature is enabled).
  - Max unsigned and most-negative signed operands are exact.
  - Counter width is max(1, clog2(B_W/STEP)). STEP=B_W gives a single MUL cycle.

Optional Feature:
- Macro SEQ_MUL_EARLY_TERM_EN.
- When defined, in unsigned mode only: at each MUL edge, if all latched b bits above the chunk just processed are zero, go to DONE at that edge. Counter wrap is irrelevant because the operation ends.
- Signed operations always run the full count.
- Product value is unchanged; only latency drops, to 1 + index of the highest non-zero chunk (min 1).
- When undefined, latency is always B_W/STEP.

Test Plan (defaults A_W=16, B_W=8, STEP=1):
- Unsigned max: a=0xFFFF, b=0xFF, sgn=0, out_rdy=1 -> out_vld at T+8, out_p=0xFEFF01, in_rdy low T+1..T+9.
- Signed small: a=0xFFFD (-3), b=0x05, sgn=1 -> out_p=0xFFFFF1 (-15).
- Signed extreme: a=0x7FFF, b=0x80 (-128), sgn=1 -> out_p=0xC00080. The same operands with sgn=0 -> 0x3FFF80.
- Backpressure: out_rdy=0 for 5 cycles after out_vld -> out_p and out_vld stable, in_rdy=0, in_vld pulses ignored. out_rdy=1 -> IDLE next cycle; the next operand is accepted the cycle after.
- Reset mid-operation: rst=1 at T+4 -> next cycle state IDLE, out_vld=0, out_p=0, in_rdy=1. No spurious out_vld follows.
- Early termination (macro defined): a=0x1234, b=0x01, sgn=0 -> out_vld at T+1, out_p=0x001234. b=0x00 -> T+1, out_p=0. a=0xFFFD, b=0x05, sgn=1 -> still T+8. Macro undefined -> all at T+8.
